// File: rtl/note_lane.sv
// note_lane: per-lane falling-note engine with a spawn queue, hit/miss
// resolution and sprite hit-test for the colour mapper.
module note_lane #(
  parameter logic [9:0] LANE_X  = 10'd150,
  parameter logic [9:0] SPEED   = 10'd2,
  parameter logic [9:0] HIT_TOP = 10'd381,
  parameter logic [9:0] HIT_BOT = 10'd450,
  parameter int         QDEPTH  = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic       key,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic       is_sprite,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  output logic       hit_pulse,
  output logic       miss_pulse,
  output logic [2:0] pending,
  output logic [7:0] hit_count
);
  typedef enum logic [1:0] {IDLE, FALL, HIT, MISS} state_t;
  state_t      state_q;
  logic        frame_q, key_q, hit_q, miss_q;
  logic [9:0]  y_q;
  logic [2:0]  pend_q, pend_d;
  logic [7:0]  hits_q;
  logic [10:0] y_d;
  logic        tick, press, pop, push, in_win;
  assign tick   = frame_clk & ~frame_q;
  assign press  = key & ~key_q;
  assign pop    = (state_q == IDLE) && (pend_q != 3'd0);
  // a spawn arriving alongside a pop always fits, even with a full queue
  assign push   = spawn && ((pend_q < 3'(QDEPTH)) || pop);
  assign pend_d = (push && !pop) ? pend_q + 3'd1 : (pop && !push) ? pend_q - 3'd1 : pend_q;
  assign y_d    = {1'b0, y_q} + {1'b0, SPEED};
  assign in_win = (y_q >= HIT_TOP) && (y_q <= HIT_BOT);
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      frame_q <= 1'b0;
      key_q   <= 1'b0;
      y_q     <= 10'd0;
      pend_q  <= 3'd0;
      hits_q  <= 8'd0;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      key_q   <= key;
      pend_q  <= pend_d;
      hit_q   <= 1'b0;
      miss_q  <= 1'b0;
      case (state_q)
        IDLE: if (pop) begin
          state_q <= FALL;
          y_q     <= 10'd0;
        end
        FALL: if (press && in_win) begin
          state_q <= HIT;
          hit_q   <= 1'b1;
          hits_q  <= hits_q + {7'd0, hits_q != 8'hff};
        end else if (tick) begin
          if (y_d > 11'd479) begin
            state_q <= MISS;
            miss_q  <= 1'b1;
          end else y_q <= y_d[9:0];
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign is_sprite  = (state_q == FALL)
                   && ({1'b0, DrawX} >= {1'b0, LANE_X}) && ({1'b0, DrawX} < {1'b0, LANE_X} + 11'd40)
                   && ({1'b0, DrawY} >= {1'b0, y_q})    && ({1'b0, DrawY} < {1'b0, y_q} + 11'd40);
  assign x_pos      = LANE_X;
  assign y_pos      = y_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign pending    = pend_q;
  assign hit_count  = hits_q;
endmodule

// File: tb/tb_note_lane.sv
// tb_note_lane: directed-vector bench for note_lane with hand-computed expectations.
module tb_note_lane;
  logic       Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0, spawn = 1'b0, key = 1'b0;
  logic [9:0] DrawX = 10'd170, DrawY = 10'd10;
  logic       is_sprite, hit_pulse, miss_pulse;
  logic [9:0] x_pos, y_pos;
  logic [2:0] pending;
  logic [7:0] hit_count;
  int         n_chk = 0, n_bad = 0;
  note_lane dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .spawn(spawn), .key(key),
    .DrawX(DrawX), .DrawY(DrawY), .is_sprite(is_sprite), .x_pos(x_pos), .y_pos(y_pos),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .pending(pending), .hit_count(hit_count)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask
  // low for one edge, then high across exactly one edge; sampled right after
  task automatic tick();
    frame_clk = 1'b0;
    cyc(1);
    frame_clk = 1'b1;
    cyc(1);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask
  task automatic press();
    key = 1'b0;
    cyc(1);
    key = 1'b1;
    cyc(1);
  endtask
  task automatic spawn_one();
    spawn = 1'b1;
    cyc(1);
    spawn = 1'b0;
  endtask
  task automatic sprite_at(input string tag, input int x, input int y, input logic exp);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 chk(tag, is_sprite, exp);
  endtask
  initial begin
    cyc(2);
    chk("rst_y", y_pos, 0);
    chk("rst_pend", pending, 0);
    chk("rst_hits", hit_count, 0);
    chk("rst_hit", hit_pulse, 0);
    chk("rst_miss", miss_pulse, 0);
    chk("rst_x", x_pos, 150);
    chk("rst_spr", is_sprite, 0);
    Reset = 1'b0;
    cyc(2);
    chk("idle_pend", pending, 0);
    // basic fall
    spawn_one();
    chk("sp_pend1", pending, 1);
    cyc(1);
    chk("sp_pend0", pending, 0);
    chk("sp_y0", y_pos, 0);
    sprite_at("spr_in", 170, 10, 1'b1);
    sprite_at("spr_xr", 190, 10, 1'b0);
    sprite_at("spr_yb", 170, 60, 1'b0);
    sprite_at("spr_corner", 189, 39, 1'b1);
    sprite_at("spr_xl", 149, 10, 1'b0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("fall_y%0d", i), y_pos, 2 * i);
    end
    frame_clk = 1'b0;
    cyc(1);
    frame_clk = 1'b1;
    cyc(4);
    chk("held_tick", y_pos, 22);
    // miss path
    ticks(228);
    chk("pre_miss_y", y_pos, 478);
    chk("pre_miss_p", miss_pulse, 0);
    tick();
    chk("miss_p", miss_pulse, 1);
    chk("miss_hp", hit_pulse, 0);
    chk("miss_y", y_pos, 478);
    sprite_at("miss_spr", 170, 480, 1'b0);
    cyc(1);
    chk("miss_p_end", miss_pulse, 0);
    chk("miss_hits", hit_count, 0);
    cyc(3);
    sprite_at("idle_spr", 170, 490, 1'b0);
    chk("idle_y", y_pos, 478);
    // hit window
    spawn_one();
    cyc(1);
    chk("hw_y0", y_pos, 0);
    ticks(190);
    chk("hw_y380", y_pos, 380);
    press();
    chk("early_hp", hit_pulse, 0);
    sprite_at("early_fall", 170, 390, 1'b1);
    tick();
    chk("hw_y382", y_pos, 382);
    press();
    chk("hit_p", hit_pulse, 1);
    chk("hit_mp", miss_pulse, 0);
    chk("hit_y", y_pos, 382);
    cyc(1);
    chk("hit_p_end", hit_pulse, 0);
    chk("hit_cnt1", hit_count, 1);
    // key held high through the window of the next note
    spawn_one();
    cyc(1);
    ticks(200);
    chk("held_y400", y_pos, 400);
    chk("held_hits", hit_count, 1);
    chk("held_hp", hit_pulse, 0);
    ticks(25);
    chk("y450", y_pos, 450);
    // simultaneous press and tick at the bottom of the window
    key = 1'b0;
    frame_clk = 1'b0;
    cyc(1);
    key = 1'b1;
    frame_clk = 1'b1;
    cyc(1);
    chk("sim_hp", hit_pulse, 1);
    chk("sim_mp", miss_pulse, 0);
    chk("sim_y", y_pos, 450);
    cyc(1);
    chk("sim_hits", hit_count, 2);
    key = 1'b0;
    cyc(2);
    // queue overflow
    spawn_one();
    cyc(1);
    chk("q_pop", pending, 0);
    spawn = 1'b1;
    cyc(5);
    spawn = 1'b0;
    chk("q_sat", pending, 3);
    ticks(240);
    chk("q_miss0", miss_pulse, 1);
    chk("q_pend3", pending, 3);
    for (int n = 1; n <= 3; n++) begin
      cyc(2);
      chk($sformatf("q_pend_n%0d", n), pending, 3 - n);
      chk($sformatf("q_y_n%0d", n), y_pos, 0);
      ticks(240);
      chk($sformatf("q_miss_n%0d", n), miss_pulse, 1);
    end
    cyc(4);
    chk("q_empty", pending, 0);
    chk("q_idle_y", y_pos, 478);
    // reset mid-fall
    spawn_one();
    cyc(1);
    ticks(100);
    chk("rm_y200", y_pos, 200);
    spawn = 1'b1;
    cyc(2);
    spawn = 1'b0;
    chk("rm_pend2", pending, 2);
    DrawY = 10'd210;
    #2 Reset = 1'b1;
    #1;
    chk("rm_y", y_pos, 0);
    chk("rm_pend", pending, 0);
    chk("rm_spr", is_sprite, 0);
    chk("rm_hits", hit_count, 0);
    chk("rm_hp", hit_pulse, 0);
    chk("rm_mp", miss_pulse, 0);
    cyc(2);
    Reset = 1'b0;
    DrawY = 10'd10;
    ticks(10);
    chk("post_y", y_pos, 0);
    chk("post_pend", pending, 0);
    chk("post_spr", is_sprite, 0);
    chk("post_mp", miss_pulse, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
